alu_iter: RTL and testbench

`alu_iter` is a parametrised, registered successor to the team's 8-bit datapath ALU. It adds explicit reset, a start/busy/done handshake, and generic operand width. It also adds iterative multiply and divide units that return full-width high results (product high half, remainder). It sits between the register file and the writeback/flag register, and the control unit starts it with a one-cycle `en` strobe.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_iter_muldiv.sv | 72 +++++++
 rtl/alu_iter.sv | 148 ++++++++++++++
 tb/tb_alu_iter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state type for the iterative ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_CMP = 4'h4;
    localparam logic [3:0] OP_INC = 4'h5;
    localparam logic [3:0] OP_DEC = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_MOD = 4'h9;
    localparam logic [3:0] OP_AND = 4'hA;
    localparam logic [3:0] OP_OR  = 4'hB;
    localparam logic [3:0] OP_XOR = 4'hC;
    localparam logic [3:0] OP_DIV = 4'hD;

    localparam int unsigned FL_C  = 0;
    localparam int unsigned FL_SH = 1;
    localparam int unsigned FL_Z  = 2;
    localparam int unsigned FL_LT = 3;
    localparam int unsigned FL_EQ = 4;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv
    } alu_state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared shift/accumulate engine: LSB-first shift-add multiply or restoring divide,
// one step per cycle for WIDTH cycles.
module alu_iter_muldiv #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic             run_q, mode_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, sr_q, op_q;
    logic [WIDTH-1:0] acc_d, sr_d;
    logic [WIDTH:0]   mul_sum, shifted, diff;

    always_comb begin
        mul_sum = {1'b0, acc_q} + (sr_q[0] ? {1'b0, op_q} : '0);
        shifted = {acc_q, sr_q[WIDTH-1]};
        diff    = shifted - {1'b0, op_q};
        if (!mode_q) begin
            acc_d = mul_sum[WIDTH:1];
            sr_d  = {mul_sum[0], sr_q[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_d = diff[WIDTH-1:0];
            sr_d  = {sr_q[WIDTH-2:0], 1'b1};
        end else begin
            // Remainder < divisor, so a negative difference always shows up in bit WIDTH
            acc_d = shifted[WIDTH-1:0];
            sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    // Results are the post-step values of the final iteration
    assign done = run_q && (cnt_q == '0);
    assign lo   = sr_d;
    assign hi   = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= 1'b0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            sr_q   <= '0;
            op_q   <= '0;
        end else if (start) begin
            run_q  <= 1'b1;
            mode_q <= mode;
            cnt_q  <= CW'(WIDTH - 1);
            acc_q  <= '0;
            sr_q   <= a;
            op_q   <= b;
        end else if (run_q) begin
            acc_q <= acc_d;
            sr_q  <= sr_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Registered ALU with start/busy/done handshake; single-cycle ops computed here,
// multiply and divide delegated to the iterative engine.
module alu_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] ans,
    output logic [WIDTH-1:0] ans_hi,
    output logic [4:0]       fl,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] ans_q, ans_d, hi_q, hi_d;
    logic [4:0]       fl_q, fl_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sc_ans, sc_hi;
    logic [4:0]       sc_fl;
    logic             sc_zf;
    logic [WIDTH:0]   sum, dif;
    logic             md_start, md_mode, md_done;
    logic [WIDTH-1:0] md_lo, md_hi;

    alu_iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk  (clk),
        .rst  (rst),
        .start(md_start),
        .mode (md_mode),
        .a    (a),
        .b    (b),
        .done (md_done),
        .lo   (md_lo),
        .hi   (md_hi)
    );

    always_comb begin
        sc_ans = '0;
        sc_hi  = '0;
        sc_fl  = '0;
        sc_zf  = 1'b1;
        sum    = {1'b0, a} + {1'b0, b};
        dif    = {1'b0, a} - {1'b0, b};
        unique case (opcode)
            OP_ADD: begin sc_ans = sum[WIDTH-1:0]; sc_fl[FL_C] = sum[WIDTH]; end
            OP_SUB: begin
                sc_ans = dif[WIDTH-1:0];
                sc_fl[FL_C]  = dif[WIDTH];
                sc_fl[FL_LT] = dif[WIDTH];
                sc_fl[FL_EQ] = (a == b);
            end
            OP_CMP: begin
                sc_zf = 1'b0;
                sc_fl[FL_LT] = dif[WIDTH];
                sc_fl[FL_EQ] = (a == b);
                sc_fl[FL_Z]  = (a == b);
            end
            OP_INC: begin sc_ans = a + One; sc_fl[FL_C] = &a; end
            OP_DEC: begin sc_ans = a - One; sc_fl[FL_C] = (a == '0); end
            OP_SHL: begin sc_ans = {a[WIDTH-2:0], 1'b0}; sc_fl[FL_SH] = a[WIDTH-1]; end
            OP_SHR: begin sc_ans = {1'b0, a[WIDTH-1:1]}; sc_fl[FL_SH] = a[0]; end
            // Only reached single-cycle when b == 0
            OP_MOD, OP_DIV: begin sc_ans = '1; sc_hi = a; sc_fl[FL_C] = 1'b1; end
            OP_AND: sc_ans = a & b;
            OP_OR:  sc_ans = a | b;
            OP_XOR: sc_ans = a ^ b;
            default: sc_zf = 1'b0;
        endcase
        if (sc_zf) begin
            sc_fl[FL_Z] = (sc_ans == '0);
        end
    end

    always_comb begin
        state_d  = state_q;
        ans_d    = ans_q;
        hi_d     = hi_q;
        fl_d     = fl_q;
        done_d   = 1'b0;
        md_start = 1'b0;
        md_mode  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    if (opcode == OP_MUL) begin
                        state_d  = StMul;
                        md_start = 1'b1;
                    end else if ((opcode == OP_DIV || opcode == OP_MOD) && b != '0) begin
                        state_d  = StDiv;
                        md_start = 1'b1;
                        md_mode  = 1'b1;
                    end else begin
                        ans_d  = sc_ans;
                        hi_d   = sc_hi;
                        fl_d   = sc_fl;
                        done_d = 1'b1;
                    end
                end
            end
            StMul, StDiv: begin
                if (md_done) begin
                    state_d     = StIdle;
                    ans_d       = md_lo;
                    hi_d        = md_hi;
                    fl_d        = '0;
                    fl_d[FL_C]  = (state_q == StMul) && (md_hi != '0);
                    fl_d[FL_Z]  = (md_lo == '0);
                    done_d      = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ans_q   <= '0;
            hi_q    <= '0;
            fl_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ans_q   <= ans_d;
            hi_q    <= hi_d;
            fl_q    <= fl_d;
            done_q  <= done_d;
        end
    end

    assign ans    = ans_q;
    assign ans_hi = hi_q;
    assign fl     = fl_q;
    assign done   = done_q;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_alu_iter.sv
// Directed checks of alu_iter at WIDTH=8 and WIDTH=16 with hand-computed results.
module tb_alu_iter;
    import alu_pkg::*;

    logic        clk, rst, en8, en16, sel;
    logic [3:0]  opcode;
    logic [15:0] a, b;
    logic [7:0]  ans8, hi8;
    logic [15:0] ans16, hi16;
    logic [4:0]  fl8, fl16;
    logic        busy8, busy16, done8, done16;
    logic [15:0] o_ans, o_hi;
    logic [4:0]  o_fl;
    logic        o_busy, o_done;
    int          checks = 0;
    int          errors = 0;
    int          lat;
    int          pulses;

    alu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .opcode(opcode), .a(a[7:0]), .b(b[7:0]),
        .ans(ans8), .ans_hi(hi8), .fl(fl8), .busy(busy8), .done(done8)
    );

    alu_iter #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .en(en16), .opcode(opcode), .a(a), .b(b),
        .ans(ans16), .ans_hi(hi16), .fl(fl16), .busy(busy16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        o_ans  = sel ? ans16 : {8'h00, ans8};
        o_hi   = sel ? hi16 : {8'h00, hi8};
        o_fl   = sel ? fl16 : fl8;
        o_busy = sel ? busy16 : busy8;
        o_done = sel ? done16 : done8;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one accept cycle; returns at the negedge following the accept edge
    task automatic issue(input bit w16, input logic [3:0] op, input logic [15:0] x,
                         input logic [15:0] y);
        @(negedge clk);
        sel = w16; opcode = op; a = x; b = y;
        if (w16) en16 = 1'b1; else en8 = 1'b1;
        @(negedge clk);
        en8 = 1'b0; en16 = 1'b0;
    endtask

    task automatic wait_done(input int start, output int n);
        n = start;
        while (o_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] e_ans,
                             input logic [15:0] e_hi, input logic [4:0] e_fl);
        check({tag, "_done"}, o_done, 1);
        check({tag, "_ans"}, o_ans, e_ans);
        check({tag, "_hi"}, o_hi, e_hi);
        check({tag, "_fl"}, o_fl, e_fl);
    endtask

    initial begin
        rst = 1'b1; en8 = 1'b0; en16 = 1'b0; sel = 1'b0;
        opcode = 4'h0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst8_out", {ans8, hi8, fl8, busy8, done8}, 0);
        check("rst16_out", {ans16, hi16}, 0);
        check("rst16_ctl", {fl16, busy16, done16}, 0);
        rst = 1'b0;

        issue(0, OP_ADD, 16'hFF, 16'h01);
        check("add_busy", o_busy, 0);
        check_res("add", 16'h00, 16'h00, 5'b00101);
        @(negedge clk);
        check("add_done_low", o_done, 0);

        issue(0, OP_MUL, 16'h10, 16'h20);
        check("mul_busy", o_busy, 1);
        check("mul_no_early_done", o_done, 0);
        opcode = OP_ADD; a = 16'h1; b = 16'h1; en8 = 1'b1;
        @(negedge clk);
        en8 = 1'b0;
        check("mul_busy_ign", o_busy, 1);
        wait_done(1, lat);
        check("mul_lat", lat, 8);
        check("mul_busy_fall", o_busy, 0);
        check_res("mul", 16'h00, 16'h02, 5'b00101);
        @(negedge clk);
        check("mul_hold_done", o_done, 0);
        check("mul_hold_hi", o_hi, 16'h02);

        issue(0, OP_DIV, 16'd200, 16'd7);
        wait_done(0, lat);
        check("div_lat", lat, 8);
        check_res("div", 16'h1C, 16'h04, 5'b00000);

        issue(0, OP_MOD, 16'd100, 16'd10);
        wait_done(0, lat);
        check("mod_lat", lat, 8);
        check_res("mod", 16'h0A, 16'h00, 5'b00000);

        issue(0, OP_DIV, 16'd9, 16'd0);
        check("div0_busy", o_busy, 0);
        check_res("div0", 16'hFF, 16'h09, 5'b00001);

        issue(0, OP_CMP, 16'd5, 16'd5);
        check_res("cmp_eq", 16'h00, 16'h00, 5'b10100);
        issue(0, OP_CMP, 16'd3, 16'd9);
        check_res("cmp_lt", 16'h00, 16'h00, 5'b01000);
        issue(0, OP_SUB, 16'd3, 16'd9);
        check_res("sub", 16'hFA, 16'h00, 5'b01001);
        issue(0, OP_SHL, 16'h81, 16'h00);
        check_res("shl", 16'h02, 16'h00, 5'b00010);
        issue(0, OP_SHR, 16'h81, 16'h00);
        check_res("shr", 16'h40, 16'h00, 5'b00010);
        issue(0, OP_DEC, 16'h00, 16'h00);
        check_res("dec", 16'hFF, 16'h00, 5'b00001);
        issue(0, 4'hE, 16'h12, 16'h34);
        check_res("illegal", 16'h00, 16'h00, 5'b00000);

        // Back-to-back single-cycle issue
        @(negedge clk);
        sel = 1'b0; opcode = OP_INC; a = 16'hFF; b = 16'h00; en8 = 1'b1;
        @(negedge clk);
        check_res("b2b_inc", 16'h00, 16'h00, 5'b00101);
        opcode = OP_XOR; a = 16'hF0; b = 16'h0F;
        @(negedge clk);
        en8 = 1'b0;
        check_res("b2b_xor", 16'hFF, 16'h00, 5'b00000);

        // Reset in the third busy cycle of a multiply
        issue(0, OP_MUL, 16'h12, 16'h34);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmul_out", {ans8, hi8, fl8, busy8, done8}, 0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1) pulses++;
        end
        check("rstmul_no_done", pulses, 0);

        issue(0, OP_MUL, 16'hFF, 16'hFF);
        wait_done(0, lat);
        check("mulff_lat", lat, 8);
        check_res("mulff", 16'h01, 16'hFE, 5'b00001);

        issue(1, OP_MUL, 16'h1234, 16'h0100);
        check("mul16_busy", o_busy, 1);
        wait_done(0, lat);
        check("mul16_lat", lat, 16);
        check_res("mul16", 16'h3400, 16'h0012, 5'b00001);

        issue(1, OP_MUL, 16'hFFFF, 16'hFFFF);
        wait_done(0, lat);
        check("mulff16_lat", lat, 16);
        check_res("mulff16", 16'h0001, 16'hFFFE, 5'b00001);

        issue(1, OP_DIV, 16'd50000, 16'd123);
        wait_done(0, lat);
        check("div16_lat", lat, 16);
        check_res("div16", 16'h0196, 16'h003E, 5'b00000);

        issue(1, OP_MOD, 16'h1234, 16'h0000);
        check_res("div0_16", 16'hFFFF, 16'h1234, 5'b00001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
